// File: rtl/mux_nto1_rr_pkg.sv
// Shared constants and helpers for the N-to-1 mux family.
// Mode and state encodings are kept as plain constants so legacy users can still compare against them.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Index width for n items; a single-item index still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Producer/consumer bundle for mux_nto1_rr.
// The mux is the slave side; the master side drives the channels and consumes the output.
interface mux_nto1_rr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
);
    import mux_pkg::*;

    localparam int unsigned SELW = idx_width(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH-1:0]       in_ack;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ack, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ack, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_nto1_rr_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping modulo NCH.
// ptr is assumed to be below NCH.
module rr_pick #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [NCH-1:0]  valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_ok
);

    logic            found;
    logic [SELW-1:0] idx_w;

    always_comb begin
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            idx_w = SELW'(idx);
            if (!found && valid[idx_w]) begin
                found = 1'b1;
                grant = idx_w;
            end
        end
        grant_ok = |valid;
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 registered mux with manual or round-robin selection and a valid/ready output stage.
// A capture and a consume can share one edge, so a steady out_ready gives one word per clock.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nto1_rr_if.slave  bus
);

    localparam int unsigned SELW = idx_width(NCH);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [SELW-1:0]  rr_grant;
    logic             rr_ok;
    logic [SELW-1:0]  grant;
    logic             grant_ok;
    logic             sel_in_range;
    logic             load;
    logic             capture;
    logic [WIDTH-1:0] grant_data;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .valid    (bus.in_valid),
        .ptr      (rr_ptr_q),
        .grant    (rr_grant),
        .grant_ok (rr_ok)
    );

    // Out-of-range sel only exists when NCH is not a power of two.
    assign sel_in_range = ({1'b0, bus.sel} < (SELW+1)'(NCH));

    always_comb begin
        if (bus.mode == MODE_RR) begin
            grant    = rr_grant;
            grant_ok = rr_ok;
        end else begin
            grant    = bus.sel;
            grant_ok = sel_in_range && bus.in_valid[bus.sel];
        end

        load    = (state_q == ST_EMPTY) || bus.out_ready;
        capture = load && grant_ok;

        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end

        bus.in_ack = '0;
        if (capture && rst_n) begin
            bus.in_ack[grant] = 1'b1;
        end

        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            state_d = capture ? ST_FULL : ST_EMPTY;
        end
        if (capture) begin
            out_data_d = grant_data;
            out_ch_d   = grant;
            if (bus.mode == MODE_RR) begin
                rr_ptr_d = (grant == SELW'(NCH-1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: stimulus predicts acks and queues expected words,
// a negedge monitor pops and compares whenever the consumer takes a word.
module tb_mux_nto1_rr;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SELW  = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        int unsigned      ch;
    } word_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    word_t       exp_q[$];
    int unsigned mptr;

    mux_nto1_rr_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference selection: manual uses sel directly, round-robin scans from the pointer with wrap.
    function automatic void ref_pick(input logic m, input int unsigned s, input logic [NCH-1:0] v,
                                     input int unsigned ptr, output bit ok, output int unsigned g);
        ok = 0;
        g  = 0;
        if (m == 1'b0) begin
            g  = s;
            ok = (s < NCH) && v[SELW'(s)];
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                int unsigned idx;
                idx = (ptr + k) % NCH;
                if (!ok && v[SELW'(idx)]) begin
                    ok = 1;
                    g  = idx;
                end
            end
        end
    endfunction

    // Called ~2 time units after a rising edge; returns ~2 units after the next one.
    task automatic step(input logic m, input int unsigned s, input logic [NCH-1:0] v,
                        input logic r, input logic [NCH*WIDTH-1:0] d);
        bit               ok;
        bit               cap;
        int unsigned      g;
        logic [NCH-1:0]   eack;
        word_t            w;
        bus.mode      = m;
        bus.sel       = SELW'(s);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_data   = d;
        #1;
        ref_pick(m, s, v, mptr, ok, g);
        cap  = ok && ((exp_q.size() == 0) || r);
        eack = '0;
        if (cap) eack[SELW'(g)] = 1'b1;
        chk("in_ack", 32'(bus.in_ack), 32'(eack));
        @(posedge clk);
        if (cap) begin
            w.d  = WIDTH'(d >> (g*WIDTH));
            w.ch = g;
            exp_q.push_back(w);
            if (m == 1'b1) mptr = (g + 1) % NCH;
        end
        #2;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_ch",    32'(bus.out_ch),    32'd0);
        chk("rst_ack",   32'(bus.in_ack),    32'd0);
        exp_q.delete();
        mptr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    // Monitor: the held word must match the queue head; it retires when out_ready is high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                if (bus.out_valid && exp_q.size() != 0) begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
                    chk("out_ch",   32'(bus.out_ch),   exp_q[0].ch);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        mptr   = 0;
        rst_n  = 1'b0;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.out_ready = 1'b0; bus.in_data = '0;
        #1;
        chk("init_valid", 32'(bus.out_valid), 32'd0);
        chk("init_data",  32'(bus.out_data),  32'd0);
        chk("init_ack",   32'(bus.in_ack),    32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Manual capture of channel 2, then backpressure while its data changes.
        step(1'b0, 2, 4'b0100, 1'b1, 32'h00A5_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 2, 4'b0100, 1'b0, 32'h003C_0000);
        chk("bp_hold", 32'(bus.out_data), 32'hA5);
        step(1'b0, 2, 4'b0100, 1'b1, 32'h003C_0000);
        step(1'b0, 2, 4'b0000, 1'b1, 32'h0);
        chk("bp_new", 32'(bus.out_data), 32'h3C);

        // Round-robin fairness from a fresh reset.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 0, 4'b1111, 1'b1, 32'h1312_1110);
        chk("rr_fifth_ch", 32'(bus.out_ch), 32'd0);

        // Move the pointer to 2, then sparse requests alternate 3,1,3,1.
        step(1'b1, 0, 4'b0010, 1'b1, 32'h1312_1110);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 4'b1010, 1'b1, 32'h1312_1110);
        chk("sparse_last", 32'(bus.out_ch), 32'd1);

        // Manual miss: sel=0 is not requesting.
        for (int i = 0; i < 2; i++) step(1'b0, 0, 4'b0110, 1'b1, 32'h1312_1110);
        chk("miss_data", 32'(bus.out_data), 32'h11);

        // Reset while a word is held, then round-robin restarts at channel 0.
        step(1'b1, 0, 4'b1111, 1'b0, 32'h4433_2211);
        do_reset();
        step(1'b1, 0, 4'b1111, 1'b1, 32'h4433_2211);
        chk("post_rst_ch", 32'(bus.out_ch), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'(($urandom_range(0, 3) != 0)), $urandom_range(0, NCH-1), NCH'($urandom),
                 1'(($urandom_range(0, 3) != 0)), $urandom);
        end
        step(1'b0, 0, 4'b0000, 1'b1, 32'h0);
        step(1'b0, 0, 4'b0000, 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
Parametrised N-to-1 multiplexer for WIDTH-bit channels with a registered output stage and valid/ready handshake. This is the next generation of the 2-to-1 mux family (cond/if/case forms).
Two selection modes:
- manual select, driven by the sel port;
- fair round-robin scan across all channels.
It sits between several producers and one consumer, for example a shared display or UART path.

Parameters:
WIDTH, 8, data bits per channel
NCH, 4, number of input channels (≥2)
SELW, $clog2(NCH), channel-index width (localparam, derived; not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NCH*WIDTH  channel data, flattened; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  channel i has data
mode  input  1  0 = manual (use sel), 1 = round-robin
sel  input  SELW  channel index, manual mode only
in_ack  output  NCH  one-hot, combinational; bit i high in the cycle channel i is captured
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  index of the channel held in out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data=0, out_ch=0, out_valid=0, rr_ptr=0;
  - in_ack=0 while reset is asserted.
  - Reset mid-transfer discards the held word. No in_ack is generated for it.
- Output stage is a 2-state FSM:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - load = (state==EMPTY) || out_ready.
- Grant logic (combinational), evaluated every cycle:
  - Manual: grant_ok = (sel<NCH) && in_valid[sel]; grant = sel.
    - sel ≥ NCH gives no grant (possible only when NCH is not a power of two).
  - Round-robin:
    - grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, …, wrapping modulo NCH.
    - grant_ok = |in_valid.
- Capture on the clock edge when load && grant_ok:
  - out_data <= channel[grant], out_ch <= grant, state <= FULL.
  - in_ack[grant]=1 in that same cycle.
- When load && !grant_ok: state <= EMPTY. out_data and out_ch hold their old values.
- When !load (FULL and !out_ready):
  - out_data, out_ch and out_valid are held stable;
  - in_ack=0;
  - inputs are ignored.
- Latency: 1 clock from capture to out_valid.
- Throughput: one word per clock when out_ready is held high.
- rr_ptr:
  - updates only on a round-robin capture: rr_ptr <= (grant==NCH-1) ? 0 : grant+1;
  - holds during manual mode;
  - is not reset by a mode change.
- A mode or sel change takes effect on the next load cycle only. It never alters a held word.
- A producer must keep in_valid[i] and its data stable until in_ack[i]. Dropping in_valid early simply removes the request.
- Simultaneous capture and consume (FULL, out_ready=1, grant_ok=1): the new word replaces the old in the same edge, with no bubble.

Decomposition:
- Shared package mux_pkg holds:
  - localparam MODE_MANUAL=1'b0, MODE_RR=1'b1;
  - state encoding ST_EMPTY/ST_FULL;
  - a clog2-based width helper.
- One natural sub-module, rr_pick, is combinational:
  - inputs: in_valid and rr_ptr;
  - outputs: grant and grant_ok;
  - it is reusable by future arbiters.

Test Plan:
1. Manual capture:
   - Stimulus: NCH=4, WIDTH=8; mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1.
   - Response: in_ack=4'b0100 in the capture cycle; next edge out_data=8'hA5, out_ch=2, out_valid=1.
2. Backpressure:
   - Stimulus: in FULL with out_data=8'hA5, hold out_ready=0 for 3 cycles while changing ch2 to 8'h3C.
   - Response: out_data stays 8'hA5 and in_ack=0 throughout; out_ready=1 then captures 8'h3C.
3. Round-robin fairness:
   - Stimulus: mode=1, in_valid=4'b1111, channel i data = 8'h10+i, out_ready=1 from reset.
   - Response: out_ch sequence 0,1,2,3,0 and out_data sequence 10,11,12,13,10, one per clock.
4. Round-robin sparse wrap:
   - Stimulus: in_valid=4'b1010 with rr_ptr=2.
   - Response: grants 3,1,3,1; channels 0 and 2 are never acked.
5. Manual miss:
   - Stimulus: mode=0, sel=0, in_valid=4'b0110, out_ready=1.
   - Response: in_ack=0, out_valid falls to 0 after the held word is consumed, out_data unchanged.
6. Async reset mid-operation:
   - Stimulus: pull rst_n low between clock edges while out_valid=1.
   - Response: out_valid=0, out_data=0 and out_ch=0 immediately. After release with mode=1 and in_valid=4'b1111, the first grant is channel 0.
